module_keypad_scan: RTL and testbench
=====================================

MODULE_KEYPAD_SCAN -- requirements
Module: module_keypad_scan

Interface
REQ-001 Parameter DEBOUNCE_N, default 4: consecutive scan ticks a key state must be stable to be accepted; legal range 2..15.
REQ-002 clk  input  1  system clock (27 MHz).
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 f  input  1  divided square wave from module_divFrec; only its rising edge is used.
REQ-005 row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 key_ack  input  1  consumer acknowledge for the current key code.
REQ-007 col_out  output  4  column drive, active-low one-hot.
REQ-008 key_code  output  4  accepted key, code = row_idx*4 + col_idx.
REQ-009 key_valid  output  1  key_code holds an unacknowledged key.
REQ-010 key_overrun  output  1  sticky flag: a key was accepted while key_valid was set.

Function
REQ-011 Shall pass row_in through a 2-FF synchronizer; all decisions use the synchronized rows.
REQ-012 Shall register f and generate a one-cycle scan_en on each 0->1 transition; there is no other timing source.
REQ-013 FSM states: SCAN, DEBOUNCE, HOLD, RELEASE; all state changes occur only on scan_en cycles, except for the handshake (REQ-019).
REQ-014 SCAN: if exactly one synchronized row is low, latch row_idx and col_idx, clear the counter, and go to DEBOUNCE with col_out frozen; otherwise rotate col_out 1110->1101->1011->0111->1110.
REQ-015 SCAN: zero rows low or two or more rows low means no key; keep rotating.
REQ-016 DEBOUNCE: if the same single row is still low, increment the counter; when the counter reaches DEBOUNCE_N-1, accept the key and go to HOLD; on any other row pattern, clear the counter, return to SCAN and resume rotation from the current column.
REQ-017 Accept: if key_valid=0, load key_code and set key_valid on the next clk edge; if key_valid=1, leave key_code unchanged and set key_overrun.
REQ-018 HOLD: col_out stays frozen; when all rows are high, clear the counter and go to RELEASE. RELEASE: all rows high increments the counter, reaching DEBOUNCE_N-1 goes to SCAN; any low row returns to HOLD with no second acceptance.
REQ-019 Handshake: key_ack=1 while key_valid=1 clears key_valid and key_overrun on the next edge. key_code holds its last value. key_ack while key_valid=0 is ignored.
REQ-020 If acceptance and key_ack occur in the same cycle, acceptance wins: key_valid=1, the new code is loaded, and key_overrun is cleared.
REQ-021 Latency from the first stable scan_en to key_valid: DEBOUNCE_N scan_en periods plus 1 clk.
REQ-022 Counter width is 4 bits and saturates; it never wraps.

Reset
REQ-023 On rst: state=SCAN, col_out=4'b1110, key_code=0, key_valid=0, key_overrun=0, counter=0, synchronizer and f-edge registers=1.
REQ-024 rst asserted mid-DEBOUNCE, HOLD or RELEASE shall abort immediately; the pending key is discarded and scanning restarts from column 0.

Structure
REQ-025 Package module_keypad_pkg shall hold the state enum, the constants ROWS=4 and COLS=4, CODE_W=4, and COL_INIT=4'b1110.
REQ-026 One sub-module, module_sync2: a generic-width 2-FF synchronizer with asynchronous active-high reset to a parameterized value, used for row_in and f.
REQ-027 Scan timing comes only from f; no internal prescaler.

Verification (bench: module_divFrec with Nciclos=24'd4, DEBOUNCE_N=4)
REQ-028 Reset, no key -> col_out cycles 1110,1101,1011,0111,1110 on successive scan_en; key_valid=0.
REQ-029 Hold row 2 low while col_out=1011 (col 2) -> after 4 scan_en, key_code=10, key_valid=1; col_out frozen at 1011.
REQ-030 Bounce: row toggles low/high/low within 3 scan_en, then stays stable -> exactly one acceptance, timed from the last stable start.
REQ-031 Key held with no ack, then released and key 5 pressed -> key_code keeps the first value, key_overrun=1; key_ack -> both flags clear next cycle.
REQ-032 Two rows low simultaneously -> no acceptance, rotation continues.
REQ-033 rst pulse during DEBOUNCE (counter=2) -> col_out=1110, key_valid stays 0, scanning restarts.

Source files
------------

// File: rtl/module_keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Helpers decode active-low row/column vectors.
package module_keypad_pkg;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int CODE_W = 4;
  localparam logic [COLS-1:0] COL_INIT = 4'b1110;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_e;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Index of the lowest zero bit; only meaningful when exactly one bit is low.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!v[i]) idx = i[1:0];
    return idx;
  endfunction

  function automatic logic one_low(input logic [3:0] v);
    logic [3:0] l;
    l = ~v;
    return (l != 4'd0) && ((l & (l - 4'd1)) == 4'd0);
  endfunction
endpackage

// File: rtl/module_sync2.sv
// Generic-width two-flop synchronizer with async active-high reset to RST_VAL.
module module_sync2 #(
  parameter int         W       = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/module_keypad_scan.sv
// 4x4 matrix keypad scanner: column rotation, debounce, release tracking and
// a valid/ack handshake, all paced by rising edges of the external f square wave.
module module_keypad_scan
  import module_keypad_pkg::*;
#(
  parameter int DEBOUNCE_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f,
  input  logic [ROWS-1:0]   row_in,
  input  logic              key_ack,
  output logic [COLS-1:0]   col_out,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_overrun
);
  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_N - 1);

  logic [ROWS-1:0] rows_s;
  logic            f_s;
  logic            scan_en;

  module_sync2 #(.W(ROWS), .RST_VAL(4'hF)) u_sync_rows (
    .clk(clk), .rst(rst), .d(row_in), .q(rows_s)
  );

  module_sync2 #(.W(1), .RST_VAL(1'b1)) u_sync_f (
    .clk(clk), .rst(rst), .d(f), .q(f_s)
  );

  state_e            state_q, state_d;
  logic [COLS-1:0]   col_q, col_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              f_prev_q, f_prev_d;
  logic              accept;
  logic              same_key;

  assign scan_en  = f_s & ~f_prev_q;
  assign same_key = one_low(rows_s) && (low_idx(rows_s) == row_idx_q);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    row_idx_d = row_idx_q;
    col_idx_d = col_idx_q;
    code_d    = code_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    f_prev_d  = f_s;
    accept    = 1'b0;

    if (scan_en) begin
      case (state_q)
        SCAN: begin
          if (one_low(rows_s)) begin
            row_idx_d = low_idx(rows_s);
            col_idx_d = low_idx(col_q);
            cnt_d     = 4'd0;
            state_d   = DEBOUNCE;
          end else begin
            col_d = {col_q[COLS-2:0], col_q[COLS-1]};
          end
        end
        DEBOUNCE: begin
          if (same_key) begin
            if (cnt_q == CNT_LAST) begin
              accept  = 1'b1;
              cnt_d   = 4'd0;
              state_d = HOLD;
            end else begin
              cnt_d = sat_inc(cnt_q);
            end
          end else begin
            // Column stays where the bounce was seen; rotation picks up from here.
            cnt_d   = 4'd0;
            state_d = SCAN;
          end
        end
        HOLD: begin
          if (rows_s == 4'hF) begin
            cnt_d   = 4'd0;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (rows_s == 4'hF) begin
            if (cnt_q == CNT_LAST) state_d = SCAN;
            else                   cnt_d   = sat_inc(cnt_q);
          end else begin
            state_d = HOLD;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    // A new acceptance takes priority over an ack landing in the same cycle.
    if (accept) begin
      if (!valid_q || key_ack) begin
        code_d  = {row_idx_q, col_idx_q};
        valid_d = 1'b1;
        ovr_d   = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (key_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      col_q     <= COL_INIT;
      cnt_q     <= 4'd0;
      row_idx_q <= 2'd0;
      col_idx_q <= 2'd0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      f_prev_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      row_idx_q <= row_idx_d;
      col_idx_q <= col_idx_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      f_prev_q  <= f_prev_d;
    end
  end

  assign col_out     = col_q;
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_overrun = ovr_q;
endmodule

// File: tb/tb_module_keypad_scan.sv
// Bench for module_keypad_scan: physical keypad model driving row_in from col_out,
// with a run-length reference model checked once per scan tick.
module tb_module_keypad_scan;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       f   = 1'b0;
  logic       rst;
  logic       key_ack;
  logic [3:0] row_in, col_out, key_code;
  logic       key_valid, key_overrun;
  logic [15:0] pressed;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 scanning, 1 debouncing, 2 held, 3 releasing.
  int         m_col, m_mode, m_run, m_row, m_kcol;
  logic [3:0] m_code;
  logic       m_valid, m_ov;

  always #5 clk = ~clk;
  always #40 f = ~f;  // f period = 8 clk, as from a divider with Nciclos=4

  function automatic logic [3:0] rows_for(input logic [15:0] p, input logic [3:0] col);
    logic [3:0] r;
    r = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (p[rr*4+cc] && !col[cc]) r[rr] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] colvec(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  assign row_in = rows_for(pressed, col_out);

  module_keypad_scan #(.DEBOUNCE_N(N)) dut (
    .clk(clk), .rst(rst), .f(f), .row_in(row_in), .key_ack(key_ack),
    .col_out(col_out), .key_code(key_code), .key_valid(key_valid),
    .key_overrun(key_overrun)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_col"},   col_out,              colvec(m_col));
    chk({tag, "_code"},  key_code,             m_code);
    chk({tag, "_valid"}, {3'b0, key_valid},    {3'b0, m_valid});
    chk({tag, "_ovr"},   {3'b0, key_overrun},  {3'b0, m_ov});
  endtask

  task automatic model_reset();
    m_col = 0; m_mode = 0; m_run = 0; m_row = 0; m_kcol = 0;
    m_code = 4'd0; m_valid = 1'b0; m_ov = 1'b0;
  endtask

  task automatic model_step(input logic ack);
    logic [3:0] low;
    bit single, acc;
    int idx;
    low = ~rows_for(pressed, colvec(m_col));
    single = ($countones(low) == 1);
    idx = 0;
    for (int i = 0; i < 4; i++) if (low[i]) idx = i;
    acc = 0;
    case (m_mode)
      0: if (single) begin m_row = idx; m_kcol = m_col; m_run = 1; m_mode = 1; end
         else m_col = (m_col + 1) % 4;
      1: if (single && idx == m_row) begin
           m_run++;
           if (m_run == N + 1) begin acc = 1; m_mode = 2; end
         end else begin m_run = 0; m_mode = 0; end
      2: if (low == 4'd0) begin m_run = 1; m_mode = 3; end
      default: if (low == 4'd0) begin
           m_run++;
           if (m_run == N + 1) m_mode = 0;
         end else m_mode = 2;
    endcase
    if (acc) begin
      if (!m_valid || ack) begin m_code = 4'(m_row * 4 + m_kcol); m_valid = 1; m_ov = 0; end
      else m_ov = 1;
    end else if (ack && m_valid) begin
      m_valid = 0; m_ov = 0;
    end
  endtask

  // One scan tick; outputs settle 25 ns after f rises, sampled at +30 (clk low).
  task automatic do_step(input logic ack, input string tag);
    @(posedge f);
    if (ack) begin #22 key_ack = 1'b1; #5 key_ack = 1'b0; #3; end
    else #30;
    model_step(ack);
    check_all(tag);
  endtask

  task automatic ack_pulse(input string tag);
    key_ack = 1'b1;
    @(posedge clk);
    #1 key_ack = 1'b0;
    if (m_valid) begin m_valid = 0; m_ov = 0; end
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; key_ack = 1'b0; pressed = 16'd0;
    model_reset();
    #23;
    check_all("reset");
    #4 rst = 1'b0;

    repeat (5) do_step(0, "rotate");

    // Key at row 2 / col 2 -> code 10.
    pressed = 16'd1 << 10;
    for (int k = 0; k < 20 && !m_valid; k++) do_step(0, "key10");
    chk("key10_code", key_code, 4'd10);
    chk("key10_valid", {3'b0, key_valid}, 4'd1);
    chk("key10_colfrozen", col_out, 4'b1011);
    repeat (3) do_step(0, "hold10");

    // Release without ack, then key 5 -> overrun, first code kept.
    pressed = 16'd0;
    repeat (6) do_step(0, "rel10");
    pressed = 16'd1 << 5;
    for (int k = 0; k < 20 && !m_ov; k++) do_step(0, "key5ovr");
    chk("ovr_code_kept", key_code, 4'd10);
    chk("ovr_flag", {3'b0, key_overrun}, 4'd1);
    ack_pulse("ack1");
    chk("ack_clears_valid", {3'b0, key_valid}, 4'd0);
    pressed = 16'd0;
    repeat (6) do_step(0, "rel5");

    // Bounce on key 7, then stable.
    pressed = 16'd1 << 7;
    for (int k = 0; k < 8 && m_mode != 1; k++) do_step(0, "b_find");
    pressed = 16'd0;      do_step(0, "b_up");
    pressed = 16'd1 << 7; do_step(0, "b_dn");
    pressed = 16'd0;      do_step(0, "b_up2");
    pressed = 16'd1 << 7;
    for (int k = 0; k < 24 && !m_valid; k++) do_step(0, "b_stable");
    chk("bounce_code", key_code, 4'd7);
    ack_pulse("ack2");
    pressed = 16'd0;
    repeat (6) do_step(0, "rel7");

    // Two rows low in column 3 -> never accepted.
    pressed = (16'd1 << 3) | (16'd1 << 11);
    repeat (10) do_step(0, "tworow");
    chk("tworow_novalid", {3'b0, key_valid}, 4'd0);
    pressed = 16'd0;
    do_step(0, "tworow_rel");

    // Reset while debouncing with counter at 2.
    pressed = 16'd1 << 6;
    for (int k = 0; k < 20 && !(m_mode == 1 && m_run == 3); k++) do_step(0, "rst_find");
    rst = 1'b1;
    #2;
    model_reset();
    check_all("rst_mid");
    #5 rst = 1'b0;
    pressed = 16'd0;
    repeat (5) do_step(0, "rst_rot");

    // Acceptance and ack on the same edge: new code wins, overrun cleared.
    pressed = 16'd1 << 10;
    for (int k = 0; k < 20 && !m_valid; k++) do_step(0, "same_a");
    pressed = 16'd0;
    repeat (6) do_step(0, "same_rel");
    pressed = 16'd1 << 5;
    for (int k = 0; k < 20 && !(m_mode == 1 && m_run == N); k++) do_step(0, "same_b");
    do_step(1, "same_edge");
    chk("same_edge_code", key_code, 4'd5);
    chk("same_edge_ovr", {3'b0, key_overrun}, 4'd0);
    ack_pulse("ack3");
    pressed = 16'd0;
    repeat (6) do_step(0, "same_rel2");

    // Randomized key activity and ack timing.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(5) == 0) begin
        case ($urandom_range(2))
          0: pressed = 16'd0;
          1: pressed = 16'd1 << $urandom_range(15);
          default: pressed = (16'd1 << $urandom_range(15)) | (16'd1 << $urandom_range(15));
        endcase
      end
      do_step($urandom_range(3) == 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
